// File: rtl/fir_token_sequencer.sv
// fir_token_sequencer
//   Upstream controller for the FIR tap token chain. For every accepted input
//   sample it loads the token into stage 0 of the chain, steps it through NTAPS
//   tap positions (one per unstalled cycle), and then checks that the token has
//   come out of the last stage. The MAC datapath gets a tap index and
//   accumulator clear/done strobes, and a lost token sets a sticky error.
//
// Parameters
//   NTAPS  number of tap stages in the chain (>= 2)
//   IDX_W  width of tap_idx (2**IDX_W >= NTAPS)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   sample_valid  upstream has a new sample
//   sample_ready  sequencer can accept a sample (IDLE only)
//   stall         datapath back-pressure; freezes token stepping in RUN
//   tok_ret       token output of the last chain stage
//   err_clr       clears the sticky tok_err
//   chain_init    loads the token into chain stage 0
//   chain_en      chain shift enable
//   tap_valid     tap_idx is valid this cycle; MAC must consume it
//   tap_idx       current tap position, 0..NTAPS-1
//   acc_clr       clear the MAC accumulator
//   acc_done      one-cycle pulse: accumulation for the sample is complete
//   tok_err       sticky: token did not return after the last tap
module fir_token_sequencer #(
  parameter int NTAPS = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             stall,
  input  logic             tok_ret,
  input  logic             err_clr,
  output logic             chain_init,
  output logic             chain_en,
  output logic             tap_valid,
  output logic [IDX_W-1:0] tap_idx,
  output logic             acc_clr,
  output logic             acc_done,
  output logic             tok_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NTAPS - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             tok_err_q, tok_err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tok_err_d = tok_err_q;
    // Clear first so that a token loss in the same cycle overrides it.
    if (err_clr) tok_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_valid) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          // Last tap leaves cnt parked on NTAPS-1 rather than wrapping.
          if (cnt_q == LAST_TAP) state_d = CHECK;
          else                   cnt_d   = cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!tok_ret) tok_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tok_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tok_err_q <= tok_err_d;
    end
  end

  // Outputs are decodes of registered state; only chain_en and tap_valid
  // see stall directly. acc_done reports the token check made during the
  // CHECK cycle itself so the done pulse lands in that cycle.
  always_comb begin
    sample_ready = (state_q == IDLE);
    chain_init   = (state_q == LOAD);
    acc_clr      = (state_q == LOAD);
    tap_valid    = (state_q == RUN) && !stall;
    chain_en     = (state_q == LOAD) || (state_q == CHECK) ||
                   ((state_q == RUN) && !stall);
    tap_idx      = (state_q == RUN) ? cnt_q : '0;
    acc_done     = (state_q == CHECK) && tok_ret;
    tok_err      = tok_err_q;
  end

endmodule

// File: tb/tb_fir_token_sequencer.sv
module tb_fir_token_sequencer;
  localparam int NTAPS = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_valid = 1'b0;
  logic             stall = 1'b0;
  logic             tok_ret;
  logic             err_clr = 1'b0;
  logic             sample_ready, chain_init, chain_en, tap_valid;
  logic [IDX_W-1:0] tap_idx;
  logic             acc_clr, acc_done, tok_err;

  int n_cmp = 0;
  int n_bad = 0;

  fir_token_sequencer #(.NTAPS(NTAPS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .stall(stall), .tok_ret(tok_ret),
    .err_clr(err_clr), .chain_init(chain_init), .chain_en(chain_en),
    .tap_valid(tap_valid), .tap_idx(tap_idx), .acc_clr(acc_clr),
    .acc_done(acc_done), .tok_err(tok_err)
  );

  always #5 clk = ~clk;

  // Chain model: counts enabled shifts since init; the token emerges from
  // the last stage once it has been shifted NTAPS times. lose_tok kills it.
  int   chain_shifts = 0;
  logic lose_tok = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          chain_shifts <= 0;
    else if (chain_init) chain_shifts <= 0;
    else if (chain_en)   chain_shifts <= chain_shifts + 1;
  end
  always_comb tok_ret = (chain_shifts == NTAPS) && !lose_tok;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in IDLE just after an edge (cycle 0). Stalls stall_len cycles
  // once tap_idx reaches stall_tap (-1 = never).
  task automatic run_sample(input int stall_tap, input int stall_len,
                            input bit lose, input bit clr_in_check,
                            input bit exp_err);
    int exp_idx = 0;
    int stalled = 0;
    int taps    = 0;
    int done_cyc = NTAPS + 2 + stall_len;
    chk("ready_c0", sample_ready, 1);
    sample_valid = 1'b1;
    lose_tok     = lose;
    tick();
    sample_valid = 1'b0;
    chk("load_c1", {chain_init, chain_en, acc_clr, sample_ready, tap_valid}, 5'b11100);
    for (int cyc = 2; cyc < done_cyc; cyc++) begin
      tick();
      stall = (exp_idx == stall_tap) && (stalled < stall_len);
      #1;
      chk("tap_idx", tap_idx, exp_idx);
      chk("tap_valid", tap_valid, !stall);
      chk("chain_en_run", chain_en, !stall);
      chk("busy_run", {sample_ready, acc_done}, 2'b00);
      if (tap_valid) taps++;
      if (stall) stalled++;
      else exp_idx++;
    end
    tick();
    // CHECK cycle: stall must be ignored here.
    stall   = 1'b1;
    err_clr = clr_in_check;
    #1;
    chk("acc_done_chk", acc_done, !lose);
    chk("check_outs", {chain_en, tap_valid, sample_ready}, 3'b100);
    chk("tap_pulses", taps, NTAPS);
    tick();
    stall   = 1'b0;
    err_clr = 1'b0;
    lose_tok = 1'b0;
    #1;
    chk("ready_after", {sample_ready, acc_done}, 2'b10);
    chk("tok_err_after", tok_err, exp_err);
  endtask

  initial begin
    // 1. Reset and idle
    #1;
    chk("rst_outs", {sample_ready, chain_init, chain_en, tap_valid, tap_idx,
                     acc_clr, acc_done, tok_err}, 10'b10_0000_0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_outs", {sample_ready, chain_init, chain_en, tap_valid, tap_idx,
                      acc_clr, acc_done, tok_err}, 10'b10_0000_0000);

    // 2. Single sample, no stall
    run_sample(-1, 0, 1'b0, 1'b0, 1'b0);

    // 3. Three stall cycles at tap 4 (acc_done at cycle 13)
    run_sample(4, 3, 1'b0, 1'b0, 1'b0);

    // 4. Lost token, sticky error, clear, and set-wins-over-clear
    run_sample(-1, 0, 1'b1, 1'b0, 1'b1);
    run_sample(-1, 0, 1'b0, 1'b0, 1'b1);
    err_clr = 1'b1;
    #1;
    chk("err_before_clr_edge", tok_err, 1);
    tick();
    err_clr = 1'b0;
    chk("err_cleared", tok_err, 0);
    run_sample(2, 1, 1'b1, 1'b1, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared2", tok_err, 0);

    // 5. Reset during RUN at tap 5, sample_valid held high
    sample_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_tap", {tap_valid, tap_idx}, 4'b1101);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {sample_ready, chain_init, chain_en, tap_valid, tap_idx,
                      acc_clr, acc_done, tok_err}, 10'b10_0000_0000);
    tick();
    chk("rst_hold", {acc_done, chain_init}, 2'b00);
    rst_n = 1'b1;
    tick();
    chk("reaccept_load", {chain_init, acc_clr}, 2'b11);
    sample_valid = 1'b0;
    tick();
    chk("restart_tap0", {tap_valid, tap_idx}, 4'b1000);
    for (int i = 0; i < NTAPS; i++) tick();
    chk("restart_done", acc_done, 1);
    tick();
    chk("restart_idle", sample_ready, 1);

    // 6. Back-to-back: sample_valid held high for 34 cycles
    begin
      int acc_cyc[$];
      int not_ready = 0;
      sample_valid = 1'b1;
      for (int c = 0; c < 34; c++) begin
        if (sample_ready) acc_cyc.push_back(c);
        else not_ready++;
        tick();
      end
      sample_valid = 1'b0;
      chk("b2b_accepts", acc_cyc.size(), 4);
      for (int k = 1; k < acc_cyc.size(); k++)
        chk("b2b_period", acc_cyc[k] - acc_cyc[k-1], NTAPS + 3);
      chk("b2b_busy_cycles", not_ready, 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
